// File: rtl/jt1943_gfxrom_arb.sv
// Six-client graphics ROM fetch scheduler onto one 16-bit SDRAM read port, one transaction outstanding.
// Define JT1943_ARB_RR_EN for round-robin grants; otherwise fixed priority char > map1 > map2 > scr1 > scr2 > obj.
module jt1943_gfxrom_arb #(
  parameter logic [21:0] CHAR_OFFSET = 22'h00000,
  parameter logic [21:0] MAP1_OFFSET = 22'h04000,
  parameter logic [21:0] MAP2_OFFSET = 22'h08000,
  parameter logic [21:0] SCR1_OFFSET = 22'h10000,
  parameter logic [21:0] SCR2_OFFSET = 22'h30000,
  parameter logic [21:0] OBJ_OFFSET  = 22'h40000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic        char_cs,
  input  logic [13:0] char_addr,
  input  logic        map1_cs,
  input  logic [13:0] map1_addr,
  input  logic        map2_cs,
  input  logic [13:0] map2_addr,
  input  logic        scr1_cs,
  input  logic [16:0] scr1_addr,
  input  logic        scr2_cs,
  input  logic [14:0] scr2_addr,
  input  logic        obj_cs,
  input  logic [16:0] obj_addr,
  output logic [15:0] char_data,
  output logic [15:0] map1_data,
  output logic [15:0] map2_data,
  output logic [15:0] scr1_data,
  output logic [15:0] scr2_data,
  output logic [15:0] obj_data,
  output logic        char_ok,
  output logic        map1_ok,
  output logic        map2_ok,
  output logic        scr1_ok,
  output logic        scr2_ok,
  output logic        obj_ok,
  output logic        sdram_req,
  output logic [21:0] sdram_addr,
  input  logic        sdram_ack,
  input  logic        sdram_dok,
  input  logic [15:0] sdram_data
);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t           state_q, state_d;
  logic [2:0]       gnt_q, gnt_d;
  logic             req_q, req_d;
  logic [21:0]      addr_q, addr_d;
  logic [5:0][16:0] la_q, la_d;
  logic [5:0][15:0] data_q, data_d;
  logic [5:0]       valid_q, valid_d;

  logic [5:0]       cs_a, match, pend;
  logic [5:0][16:0] addr_a;
  logic [2:0]       sel;
  logic             any_pend;
  logic             grant;

  assign cs_a      = {obj_cs, scr2_cs, scr1_cs, map2_cs, map1_cs, char_cs};
  assign addr_a[0] = {3'd0, char_addr};
  assign addr_a[1] = {3'd0, map1_addr};
  assign addr_a[2] = {3'd0, map2_addr};
  assign addr_a[3] = scr1_addr;
  assign addr_a[4] = {2'd0, scr2_addr};
  assign addr_a[5] = obj_addr;

  function automatic logic [21:0] offset_of(input logic [2:0] idx);
    case (idx)
      3'd1:    offset_of = MAP1_OFFSET;
      3'd2:    offset_of = MAP2_OFFSET;
      3'd3:    offset_of = SCR1_OFFSET;
      3'd4:    offset_of = SCR2_OFFSET;
      3'd5:    offset_of = OBJ_OFFSET;
      default: offset_of = CHAR_OFFSET;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      match[i] = valid_q[i] && (addr_a[i] == la_q[i]);
    end
    pend = cs_a & ~match;
  end

  assign {obj_ok, scr2_ok, scr1_ok, map2_ok, map1_ok, char_ok} = cs_a & match;
  assign char_data  = data_q[0];
  assign map1_data  = data_q[1];
  assign map2_data  = data_q[2];
  assign scr1_data  = data_q[3];
  assign scr2_data  = data_q[4];
  assign obj_data   = data_q[5];
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  assign grant = (state_q == IDLE) && any_pend && !downloading;

`ifdef JT1943_ARB_RR_EN
  logic [2:0] ptr_q, ptr_d;

  // Scan downwards so the candidate closest to the pointer is the one kept.
  always_comb begin
    logic [3:0] idx4;
    sel      = 3'd0;
    any_pend = 1'b0;
    idx4     = 4'd0;
    for (int i = 5; i >= 0; i--) begin
      idx4 = {1'b0, ptr_q} + 4'(i);
      if (idx4 >= 4'd6) idx4 = idx4 - 4'd6;
      if (pend[idx4[2:0]]) begin
        sel      = idx4[2:0];
        any_pend = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant) ptr_d = (sel == 3'd5) ? 3'd0 : sel + 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 3'd0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    sel      = 3'd0;
    any_pend = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (pend[i]) begin
        sel      = 3'(i);
        any_pend = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    la_d    = la_q;
    data_d  = data_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (grant) begin
          gnt_d          = sel;
          la_d[sel]      = addr_a[sel];
          valid_d[sel]   = 1'b0;
          req_d          = 1'b1;
          addr_d         = offset_of(sel) + {5'd0, addr_a[sel]};
          state_d        = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          req_d = 1'b0;
          if (sdram_dok) begin
            data_d[gnt_q]  = sdram_data;
            valid_d[gnt_q] = 1'b1;
            state_d        = IDLE;
          end else begin
            state_d = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (sdram_dok) begin
          data_d[gnt_q]  = sdram_data;
          valid_d[gnt_q] = 1'b1;
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A ROM load invalidates every cached word, including one landing right now.
    if (downloading) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 3'd0;
      req_q   <= 1'b0;
      addr_q  <= 22'd0;
      la_q    <= '0;
      data_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      la_q    <= la_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_jt1943_gfxrom_arb.sv
// Randomised scoreboard bench for jt1943_gfxrom_arb with an SDRAM responder model.
module tb_jt1943_gfxrom_arb;

  localparam logic [21:0] TB_SCR1_OFF = 22'h3F0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        downloading = 1'b0;
  logic [5:0]  cs = '0;
  logic [16:0] caddr [6];
  logic [15:0] datav [6];
  logic [5:0]  okv;
  logic        sdram_req, sdram_ack, sdram_dok;
  logic [21:0] sdram_addr;
  logic [15:0] sdram_data;
  logic        auto_rsp = 1'b1;
  logic        auto_ack = 1'b0, auto_dok = 1'b0, man_ack = 1'b0, man_dok = 1'b0;
  logic [15:0] auto_data = '0, man_data = '0;
  int          fix_ack = -1, fix_dok = -1;
  int          n_cmp = 0, n_bad = 0;
  int          rr_ptr = 0;
  logic [21:0] exp_q [$];
  logic        mon_prev = 1'b0;
  logic [21:0] mon_cur = '0;

  assign sdram_ack  = auto_ack | man_ack;
  assign sdram_dok  = auto_dok | man_dok;
  assign sdram_data = man_dok ? man_data : auto_data;

  always #5 clk = ~clk;

  jt1943_gfxrom_arb #(.SCR1_OFFSET(TB_SCR1_OFF)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .char_cs(cs[0]), .char_addr(caddr[0][13:0]),
    .map1_cs(cs[1]), .map1_addr(caddr[1][13:0]),
    .map2_cs(cs[2]), .map2_addr(caddr[2][13:0]),
    .scr1_cs(cs[3]), .scr1_addr(caddr[3][16:0]),
    .scr2_cs(cs[4]), .scr2_addr(caddr[4][14:0]),
    .obj_cs(cs[5]),  .obj_addr(caddr[5][16:0]),
    .char_data(datav[0]), .map1_data(datav[1]), .map2_data(datav[2]),
    .scr1_data(datav[3]), .scr2_data(datav[4]), .obj_data(datav[5]),
    .char_ok(okv[0]), .map1_ok(okv[1]), .map2_ok(okv[2]),
    .scr1_ok(okv[3]), .scr2_ok(okv[4]), .obj_ok(okv[5]),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr),
    .sdram_ack(sdram_ack), .sdram_dok(sdram_dok), .sdram_data(sdram_data)
  );

  function automatic logic [21:0] off_of(int i);
    case (i)
      1: return 22'h04000;
      2: return 22'h08000;
      3: return TB_SCR1_OFF;
      4: return 22'h30000;
      5: return 22'h40000;
      default: return 22'h00000;
    endcase
  endfunction

  function automatic int width_of(int i);
    case (i)
      3, 5: return 17;
      4: return 15;
      default: return 14;
    endcase
  endfunction

  function automatic logic [15:0] memval(logic [21:0] a);
    logic [21:0] p;
    p = a * 22'd40503;
    return p[15:0] ^ {10'd0, a[21:16]} ^ 16'h5A5A;
  endfunction

  function automatic logic [21:0] exp_addr(int i);
    return off_of(i) + {5'd0, caddr[i]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Reference arbitration: every pending client is served once, in grant order.
  task automatic push_order(input logic [5:0] m);
    int start;
    int idx;
    start = rr_ptr;
    for (int k = 0; k < 6; k++) begin
`ifdef JT1943_ARB_RR_EN
      idx = (start + k) % 6;
`else
      idx = k;
`endif
      if (m[idx]) begin
        exp_q.push_back(exp_addr(idx));
        rr_ptr = (idx + 1) % 6;
      end
    end
  endtask

  task automatic wait_ok(input logic [5:0] m, input int budget, input string nm);
    int k;
    k = 0;
    while (((okv & m) != m) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check(nm, {26'd0, okv & m}, {26'd0, m});
  endtask

  task automatic wait_req(input int budget, input string nm);
    int k;
    k = 0;
    while (!sdram_req && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    check(nm, {31'd0, sdram_req}, 32'd1);
  endtask

  // Scoreboard monitor: each new request must match the next expected address.
  initial begin
    forever begin
      @(negedge clk);
      if (sdram_req && !mon_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL req_order: got request %0h, expected none", sdram_addr);
        end else begin
          mon_cur = exp_q.pop_front();
          check("req_addr", {10'd0, sdram_addr}, {10'd0, mon_cur});
        end
      end else if (sdram_req) begin
        check("req_addr_stable", {10'd0, sdram_addr}, {10'd0, mon_cur});
      end
      mon_prev = sdram_req;
    end
  end

  // SDRAM responder: random ack/dok spacing, sometimes ack and dok together.
  initial begin
    logic [21:0] a;
    int da, dd;
    bit both;
    forever begin
      @(negedge clk);
      if (auto_rsp && sdram_req && rst_n) begin
        a    = sdram_addr;
        da   = (fix_ack >= 0) ? fix_ack : int'($urandom_range(0, 2));
        dd   = (fix_dok >= 0) ? fix_dok : int'($urandom_range(0, 3));
        both = (fix_ack < 0) && ($urandom_range(0, 3) == 0);
        repeat (da) @(negedge clk);
        if (both) begin
          auto_ack = 1'b1; auto_dok = 1'b1; auto_data = memval(a);
          @(negedge clk);
          auto_ack = 1'b0; auto_dok = 1'b0;
        end else begin
          auto_ack = 1'b1;
          @(negedge clk);
          auto_ack = 1'b0;
          repeat (dd) @(negedge clk);
          auto_dok = 1'b1; auto_data = memval(a);
          @(negedge clk);
          auto_dok = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] m;
    for (int i = 0; i < 6; i++) caddr[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, sdram_req}, 32'd0);
    check("rst_addr", {10'd0, sdram_addr}, 32'd0);
    check("rst_ok", {26'd0, okv}, 32'd0);
    for (int i = 0; i < 6; i++) check($sformatf("rst_data%0d", i), {16'd0, datav[i]}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // First fetch: fixed responder delays, one-cycle request latency.
    fix_ack = 2; fix_dok = 3;
    caddr[0] = 17'h0123;
    cs[0] = 1'b1;
    push_order(6'b000001);
    @(negedge clk);
    check("req_latency", {31'd0, sdram_req}, 32'd1);
    wait_ok(6'b000001, 100, "char_first_ok");
    check("char_first_data", {16'd0, datav[0]}, {16'd0, memval(22'h000123)});
    fix_ack = -1; fix_dok = -1;

    for (int it = 0; it < 30; it++) begin
      downloading = 1'b1;
      case (it)
        0: m = 6'b100001;
        1: m = 6'b101010;
        2: m = 6'b001000;
        default: m = 6'($urandom_range(1, 63));
      endcase
      for (int i = 0; i < 6; i++) begin
        cs[i] = m[i];
        caddr[i] = 17'($urandom) & ((17'd1 << width_of(i)) - 17'd1);
      end
      if (it == 2) caddr[3] = 17'h1FFFF;
      repeat (4) @(negedge clk);
      check("dl_req", {31'd0, sdram_req}, 32'd0);
      check("dl_ok", {26'd0, okv}, 32'd0);
      push_order(m);
      downloading = 1'b0;
      wait_ok(m, 400, "rand_ok");
      for (int i = 0; i < 6; i++) begin
        check($sformatf("rand_ok%0d", i), {31'd0, okv[i]}, {31'd0, m[i]});
        if (m[i]) check($sformatf("rand_data%0d", i), {16'd0, datav[i]}, {16'd0, memval(exp_addr(i))});
      end
    end

    // Address change while the fetch is in flight.
    cs = '0;
    downloading = 1'b1;
    @(negedge clk);
    downloading = 1'b0;
    auto_rsp = 1'b0;
    caddr[0] = 17'h10;
    cs[0] = 1'b1;
    push_order(6'b000001);
    wait_req(50, "chg_req1");
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    caddr[0] = 17'h11;
    @(negedge clk);
    man_dok = 1'b1; man_data = 16'h1111;
    @(negedge clk);
    man_dok = 1'b0;
    check("chg_ok_stale", {31'd0, okv[0]}, 32'd0);
    check("chg_data_stale", {16'd0, datav[0]}, 32'h1111);
    push_order(6'b000001);
    wait_req(50, "chg_req2");
    man_ack = 1'b1; man_dok = 1'b1; man_data = 16'h2222;
    @(negedge clk);
    man_ack = 1'b0; man_dok = 1'b0;
    wait_ok(6'b000001, 50, "chg_ok_new");
    check("chg_data_new", {16'd0, datav[0]}, 32'h2222);

    // Reset during WAIT_DATA, then a stray dok.
    caddr[1] = 17'h0ABC;
    cs[1] = 1'b1;
    push_order(6'b000010);
    wait_req(50, "rst_mid_req");
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", {31'd0, sdram_req}, 32'd0);
    check("rst_mid_ok", {26'd0, okv}, 32'd0);
    @(negedge clk);
    cs = '0;
    rst_n = 1'b1;
    @(negedge clk);
    man_dok = 1'b1; man_data = 16'hDEAD;
    @(negedge clk);
    man_dok = 1'b0;
    repeat (3) @(negedge clk);
    check("stray_req", {31'd0, sdram_req}, 32'd0);
    for (int i = 0; i < 6; i++) check($sformatf("stray_data%0d", i), {16'd0, datav[i]}, 32'd0);
    check("exp_q_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
